mc_control_unit: RTL

- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and issues per-state datapath controls.
- Holds in memory states on a mem_req/mem_ready handshake and times out to a fault state.
- Sits between the instruction register opcode field and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_wait_timer.sv | 43 ++++
 rtl/mc_control_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states and datapath
// select values.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StImmEx   = 4'd11,
    StImmWb   = 4'd12,
    StIllegal = 4'd13,
    StFault   = 4'd14
  } mc_state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_SLT   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // States that hold on the memory handshake and are covered by the wait timer.
  function automatic logic is_wait_state(mc_state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Per-access memory wait counter; flags a timeout when mem_ready stays low for MEM_TIMEOUT
// cycles of one access. MEM_TIMEOUT = 0 disables the timeout.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          Enabled = (MEM_TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            stalled;

  assign stalled = Enabled && active && !mem_ready;

  // Saturates at the last count; the FSM leaves the wait state on that cycle anyway.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (start) begin
      wait_cnt_d = '0;
    end else if (stalled && (wait_cnt_q != CntLast)) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  assign timeout = stalled && (wait_cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction through fetch/decode/execute/
// memory/writeback and drives the shared datapath selects, with a memory-wait timeout.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          SUPPORT_IMM = 1'b1,
  parameter int unsigned STATE_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                lu_write,
  output logic                slti_en,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_fault,
  output logic [STATE_W-1:0]  state_o
);

  localparam logic [OPCODE_W-1:0] OpRtype = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OpBne   = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] OpLui   = OPCODE_W'(OP_LUI);
  localparam logic [OPCODE_W-1:0] OpSlti  = OPCODE_W'(OP_SLTI);

  mc_state_e           state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                bus_fault_q, bus_fault_d;
  logic                wait_start, wait_active, timeout;
  logic                is_slti, is_lui;

  assign is_slti = (op_q == OpSlti);
  assign is_lui  = (op_q == OpLui);

  // Counter restarts on every fresh entry into a handshake state.
  assign wait_start  = (state_d != state_q) && is_wait_state(state_d);
  assign wait_active = is_wait_state(state_q);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wait_start),
    .active   (wait_active),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bus_fault_d = bus_fault_q | timeout;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        op_d = opcode;
        case (opcode)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRtype:        state_d = StExec;
          OpBeq, OpBne:   state_d = StBranch;
          OpJ:            state_d = StJump;
          OpLui, OpSlti:  state_d = SUPPORT_IMM ? StImmEx : StIllegal;
          default:        state_d = StIllegal;
        endcase
      end
      StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFault;
      end
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (timeout) state_d = StFault;
      end
      StExec:   state_d = StAluWb;
      StImmEx:  state_d = StImmWb;
      StMemWb, StAluWb, StBranch, StJump, StImmWb, StIllegal: state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      bus_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bus_fault_q <= bus_fault_d;
    end
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    alu_op        = ALU_OP_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    lu_write      = 1'b0;
    slti_en       = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = ALU_B_IMM_SH2;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      StAluWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        branch_ne     = (op_q == OpBne);
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      StImmEx: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_op    = is_slti ? ALU_OP_SLT : ALU_OP_ADD;
        slti_en   = is_slti;
        lu_write  = is_lui;
      end
      StImmWb: begin
        reg_write  = 1'b1;
        slti_en    = is_slti;
        lu_write   = is_lui;
        instr_done = 1'b1;
      end
      StIllegal: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign mem_req   = mem_read | mem_write;
  assign bus_fault = bus_fault_q;
  assign state_o   = STATE_W'(state_q);

endmodule
